// File: rtl/tmds_rx_pkg.sv
// ============================================================================
// Module : tmds_rx_pkg
// Brief  : Shared definitions for the TMDS receive path: control-token codes,
//          the phase-calibration FSM encoding and the token-detect helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tmds_rx_pkg;

  // The four 10-bit TMDS control-period characters (C1,C0 = 00,01,10,11).
  localparam logic [9:0] TOKEN_0 = 10'h354;
  localparam logic [9:0] TOKEN_1 = 10'h0AB;
  localparam logic [9:0] TOKEN_2 = 10'h154;
  localparam logic [9:0] TOKEN_3 = 10'h2AB;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_DESER_RST = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_EVAL      = 3'd4,
    ST_COMMIT    = 3'd5,
    ST_DONE      = 3'd6,
    ST_FAIL      = 3'd7
  } cal_state_e;

  function automatic logic is_token(input logic [9:0] word);
    return (word == TOKEN_0) || (word == TOKEN_1) ||
           (word == TOKEN_2) || (word == TOKEN_3);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tmds_rx_phase_cal_tap_eval.sv
// ============================================================================
// Module : tmds_tap_eval
// Brief  : Per-tap token counter and longest-run tracker for one channel sweep.
//          Ports: clear   - drop counter and all run state
//                 measure - count a token seen on word this cycle
//                 eval    - close the current tap (good = count >= MIN_TOK)
//                 tap     - tap index being evaluated
//                 word    - recovered 10-bit word of the swept channel
//                 best_start/best_len - earliest longest run of good taps
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_tap_eval #(
  parameter int WIN_CYC = 4096,
  parameter int MIN_TOK = 256
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       clear,
  input  logic       measure,
  input  logic       eval,
  input  logic [3:0] tap,
  input  logic [9:0] word,
  output logic [3:0] best_start,
  output logic [4:0] best_len
);
  import tmds_rx_pkg::*;

  localparam int               CNT_W   = $clog2(WIN_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] tok_cnt_q, tok_cnt_d;
  logic [3:0]       cur_start_q, cur_start_d;
  logic [4:0]       cur_len_q, cur_len_d;
  logic [3:0]       best_start_q, best_start_d;
  logic [4:0]       best_len_q, best_len_d;
  logic             good;
  logic [3:0]       run_start;
  logic [4:0]       run_len;

  always_comb begin
    tok_cnt_d    = tok_cnt_q;
    cur_start_d  = cur_start_q;
    cur_len_d    = cur_len_q;
    best_start_d = best_start_q;
    best_len_d   = best_len_q;
    good         = (32'(tok_cnt_q) >= 32'(MIN_TOK));
    // A run starts at this tap only if the previous tap broke the run.
    run_start    = (cur_len_q == 5'd0) ? tap : cur_start_q;
    run_len      = cur_len_q + 5'd1;

    if (clear) begin
      tok_cnt_d    = '0;
      cur_start_d  = '0;
      cur_len_d    = '0;
      best_start_d = '0;
      best_len_d   = '0;
    end else begin
      if (measure && is_token(word) && (tok_cnt_q != '1)) begin
        tok_cnt_d = tok_cnt_q + CNT_ONE;
      end
      if (eval) begin
        tok_cnt_d = '0;
        if (good) begin
          cur_start_d = run_start;
          cur_len_d   = run_len;
          // Strictly greater keeps the earliest run on a tie.
          if (run_len > best_len_q) begin
            best_start_d = run_start;
            best_len_d   = run_len;
          end
        end else begin
          cur_len_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tok_cnt_q    <= '0;
      cur_start_q  <= '0;
      cur_len_q    <= '0;
      best_start_q <= '0;
      best_len_q   <= '0;
    end else begin
      tok_cnt_q    <= tok_cnt_d;
      cur_start_q  <= cur_start_d;
      cur_len_q    <= cur_len_d;
      best_start_q <= best_start_d;
      best_len_q   <= best_len_d;
    end
  end

  assign best_start = best_start_q;
  assign best_len   = best_len_q;

endmodule

`default_nettype wire

// File: rtl/tmds_rx_phase_cal.sv
// ============================================================================
// Module : tmds_rx_phase_cal
// Brief  : Brings the 3-channel TMDS deserializer from PLL lock to calibrated
//          operation, sweeping the 16 delay taps of each channel in turn and
//          committing the centre of the longest run of token-rich taps.
//          Inputs : clk, rstn (async, active low), PLLlock, RECAL,
//                   RAWDATAch0..2 (word-aligned, clk-synchronous)
//          Outputs: RSTNdeser, EN, PHASELch0..2, CALbusy, CALdone, CALfail
//                   (all registered)
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tmds_rx_phase_cal #(
  parameter int LOCK_CYC   = 1024,
  parameter int RST_CYC    = 16,
  parameter int SETTLE_CYC = 64,
  parameter int WIN_CYC    = 4096,
  parameter int MIN_TOK    = 256,
  parameter int RETRY_CYC  = 65536
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       PLLlock,
  input  logic       RECAL,
  input  logic [9:0] RAWDATAch0,
  input  logic [9:0] RAWDATAch1,
  input  logic [9:0] RAWDATAch2,
  output logic       RSTNdeser,
  output logic       EN,
  output logic [3:0] PHASELch0,
  output logic [3:0] PHASELch1,
  output logic [3:0] PHASELch2,
  output logic       CALbusy,
  output logic       CALdone,
  output logic       CALfail
);
  import tmds_rx_pkg::*;

  localparam int TMR_MAX = max_int(max_int(LOCK_CYC, RST_CYC),
                                   max_int(max_int(SETTLE_CYC, WIN_CYC), RETRY_CYC));
  localparam int               TMR_W       = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] TMR_ONE     = TMR_W'(1);
  localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_CYC - 1);
  localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYC - 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] WIN_LAST    = TMR_W'(WIN_CYC - 1);
  localparam logic [TMR_W-1:0] RETRY_LAST  = TMR_W'(RETRY_CYC - 1);

  cal_state_e        state_q, state_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [1:0]        ch_q, ch_d;
  logic [3:0]        tap_q, tap_d;
  logic              fail_flag_q, fail_flag_d;
  logic              rstn_deser_q, rstn_deser_d;
  logic              en_q, en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fail_q, fail_d;
  logic [2:0][3:0]   phasel_q, phasel_d;

  logic              ev_clear, ev_measure, ev_eval;
  logic [9:0]        sel_word;
  logic [3:0]        best_start;
  logic [4:0]        best_len;

  always_comb begin
    case (ch_q)
      2'd0:    sel_word = RAWDATAch0;
      2'd1:    sel_word = RAWDATAch1;
      default: sel_word = RAWDATAch2;
    endcase
  end

  tmds_tap_eval #(
    .WIN_CYC (WIN_CYC),
    .MIN_TOK (MIN_TOK)
  ) u_tap_eval (
    .clk        (clk),
    .rstn       (rstn),
    .clear      (ev_clear),
    .measure    (ev_measure),
    .eval       (ev_eval),
    .tap        (tap_q),
    .word       (sel_word),
    .best_start (best_start),
    .best_len   (best_len)
  );

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q + TMR_ONE;
    ch_d         = ch_q;
    tap_d        = tap_q;
    fail_flag_d  = fail_flag_q;
    rstn_deser_d = rstn_deser_q;
    en_d         = en_q;
    busy_d       = busy_q;
    done_d       = done_q;
    fail_d       = fail_q;
    phasel_d     = phasel_q;
    ev_clear     = 1'b0;
    ev_measure   = 1'b0;
    ev_eval      = 1'b0;

    if ((state_q != ST_WAIT_LOCK) && !PLLlock) begin
      // Lock loss wins over everything; committed taps are deliberately kept.
      state_d      = ST_WAIT_LOCK;
      timer_d      = '0;
      ch_d         = '0;
      tap_d        = '0;
      fail_flag_d  = 1'b0;
      rstn_deser_d = 1'b0;
      en_d         = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      ev_clear     = 1'b1;
    end else begin
      case (state_q)
        ST_WAIT_LOCK: begin
          ev_clear = 1'b1;
          if (!PLLlock) begin
            timer_d = '0;
          end else if (timer_q == LOCK_LAST) begin
            state_d = ST_DESER_RST;
            timer_d = '0;
          end
        end
        ST_DESER_RST: begin
          ev_clear = 1'b1;
          if (timer_q == RST_LAST) begin
            state_d      = ST_SETTLE;
            timer_d      = '0;
            rstn_deser_d = 1'b1;
            en_d         = 1'b1;
            busy_d       = 1'b1;
            fail_d       = 1'b0;
            fail_flag_d  = 1'b0;
            ch_d         = '0;
            tap_d        = '0;
          end
        end
        ST_SETTLE: begin
          phasel_d[ch_q] = tap_q;
          if (timer_q == SETTLE_LAST) begin
            state_d = ST_MEASURE;
            timer_d = '0;
          end
        end
        ST_MEASURE: begin
          ev_measure = 1'b1;
          if (timer_q == WIN_LAST) begin
            state_d = ST_EVAL;
            timer_d = '0;
          end
        end
        ST_EVAL: begin
          ev_eval = 1'b1;
          timer_d = '0;
          if (tap_q != 4'd15) begin
            tap_d   = tap_q + 4'd1;
            state_d = ST_SETTLE;
          end else begin
            state_d = ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          ev_clear = 1'b1;
          timer_d  = '0;
          if (best_len != 5'd0) begin
            // Centre of the run, rounding toward the run start.
            phasel_d[ch_q] = 4'(best_start + ((best_len - 5'd1) >> 1));
          end else begin
            phasel_d[ch_q] = 4'd0;
            fail_flag_d    = 1'b1;
          end
          if (ch_q != 2'd2) begin
            ch_d    = ch_q + 2'd1;
            tap_d   = '0;
            state_d = ST_SETTLE;
          end else if (fail_flag_d) begin
            state_d = ST_FAIL;
            busy_d  = 1'b0;
            fail_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        ST_DONE: begin
          timer_d = '0;
          if (RECAL) begin
            state_d      = ST_DESER_RST;
            done_d       = 1'b0;
            rstn_deser_d = 1'b0;
            en_d         = 1'b0;
          end
        end
        ST_FAIL: begin
          if (RECAL || (timer_q == RETRY_LAST)) begin
            state_d      = ST_DESER_RST;
            timer_d      = '0;
            rstn_deser_d = 1'b0;
            en_d         = 1'b0;
          end
        end
        default: begin
          state_d = ST_WAIT_LOCK;
          timer_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= ST_WAIT_LOCK;
      timer_q      <= '0;
      ch_q         <= '0;
      tap_q        <= '0;
      fail_flag_q  <= 1'b0;
      rstn_deser_q <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      phasel_q     <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      ch_q         <= ch_d;
      tap_q        <= tap_d;
      fail_flag_q  <= fail_flag_d;
      rstn_deser_q <= rstn_deser_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      phasel_q     <= phasel_d;
    end
  end

  assign RSTNdeser = rstn_deser_q;
  assign EN        = en_q;
  assign PHASELch0 = phasel_q[0];
  assign PHASELch1 = phasel_q[1];
  assign PHASELch2 = phasel_q[2];
  assign CALbusy   = busy_q;
  assign CALdone   = done_q;
  assign CALfail   = fail_q;

endmodule

`default_nettype wire
